// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry holding register drained by valid/ready.
// Line fall to data_valid is 2 + HALF + 9*CLKS_PER_BIT + 1 cycles; RTS drops while the register is full.
module uart_rx #(
  parameter int CLK_FREQ = 150_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       UARTn_RXD,
  output logic       UARTn_RTS,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  // CLKS_PER_BIT must be at least 4 so that the mid-bit sample point is distinct from the bit edges.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic          rxd_m;
  logic          rxd_s;
  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nx;
  logic          stop_good;
  logic          stop_bad;
  logic          load;
  logic          valid_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= UARTn_RXD;
      rxd_s <= rxd_m;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    idx_nx    = idx;
    shreg_nx  = shreg;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (!rxd_s) state_nx = S_START;
      end
      S_START: begin
        if (cnt == CNT_MID) begin
          cnt_nx   = '0;
          idx_nx   = 3'd0;
          state_nx = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rxd_s, shreg[7:1]};
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          // Returning to IDLE at mid-stop lets the next start bit follow with no gap.
          if (rxd_s) begin
            stop_good = 1'b1;
            state_nx  = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_nx = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        cnt_nx = '0;
        if (rxd_s) state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // A byte may load into a full register only when the current byte leaves in the same cycle.
  assign load     = stop_good && (!data_valid || data_ready);
  assign valid_nx = load ? 1'b1 : ((data_valid && data_ready) ? 1'b0 : data_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      UARTn_RTS   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shreg       <= shreg_nx;
      if (load) data_out <= shreg;
      data_valid  <= valid_nx;
      frame_err   <= stop_bad;
      overrun_err <= stop_good && !load;
      UARTn_RTS   <= ~valid_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: bytes are queued as frames are driven
// and popped on every data_valid & data_ready transfer.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rts;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       frame_err;
  logic       overrun_err;

  uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .UARTn_RXD  (rxd),
    .UARTn_RTS  (rts),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  int xfer_cnt = 0;
  int rise_cnt = 0;
  int vhigh_cnt = 0;
  int rts_low_cnt = 0;
  int ferr_cnt = 0;
  int oerr_cnt = 0;
  int last_rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic armed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid && data_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("extra_out", 32'(exp_q.size()), 32'd1);
        else check("data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
      if (data_valid && !prev_valid) begin
        rise_cnt++;
        last_rise_cyc = cyc;
      end
      if (data_valid) vhigh_cnt++;
      if (frame_err) ferr_cnt++;
      if (overrun_err) oerr_cnt++;
      if (frame_err || overrun_err) check("err_excl", {31'h0, frame_err & overrun_err}, 32'd0);
      if (armed) begin
        check("rts_vs_valid", {31'h0, rts}, {31'h0, ~data_valid});
        if (!rts) rts_low_cnt++;
      end
    end
    prev_valid = data_valid;
  end

  task automatic hold_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_bit(b[i], CPB);
    hold_bit(stop, CPB);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, {24'h0, data_out}, 32'h0);
    check({tag, "_valid"}, {31'h0, data_valid}, 32'd0);
    check({tag, "_ferr"}, {31'h0, frame_err}, 32'd0);
    check({tag, "_oerr"}, {31'h0, overrun_err}, 32'd0);
    check({tag, "_rts"}, {31'h0, rts}, 32'd0);
  endtask

  int c0, r0, v0, l0, f0, o0, x0;

  initial begin
    // Reset state
    #23;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rts_after_rst", {31'h0, rts}, 32'd1);
    hold_bit(1'b1, 4);

    // 0xA5 with latency and single-cycle valid/RTS-low
    r0 = rise_cnt; v0 = vhigh_cnt; l0 = rts_low_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    wait_drain("drain_a5", 40);
    repeat (3) @(negedge clk);
    check("latency", 32'(last_rise_cyc - c0), 32'(LAT));
    check("a5_rises", 32'(rise_cnt - r0), 32'd1);
    check("a5_vhigh", 32'(vhigh_cnt - v0), 32'd1);
    check("a5_rts_low", 32'(rts_low_cnt - l0), 32'd1);
    check("a5_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Short glitch is a false start, then 0x3C
    @(posedge clk); #1;
    r0 = rise_cnt;
    hold_bit(1'b0, 4);
    hold_bit(1'b1, 2 * CPB);
    check("glitch_no_out", 32'(rise_cnt - r0), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_drain("drain_3c", 40);

    // Bad stop followed by a break, then 0x0F
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    hold_bit(1'b0, 40);
    hold_bit(1'b1, CPB);
    check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("break_no_out", 32'(rise_cnt - r0), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_drain("drain_0f", 40);
    check("ferr_after_0f", 32'(ferr_cnt - f0), 32'd1);

    // Overrun: 0x11 held, 0x22 dropped
    data_ready = 1'b0;
    o0 = oerr_cnt; x0 = xfer_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold_bit(1'b1, CPB);
    check("ovr_pulse", 32'(oerr_cnt - o0), 32'd1);
    check("ovr_dout", {24'h0, data_out}, 32'h11);
    check("ovr_valid", {31'h0, data_valid}, 32'd1);
    check("ovr_rts", {31'h0, rts}, 32'd0);
    data_ready = 1'b1;
    wait_drain("drain_11", 10);
    repeat (2) @(negedge clk);
    check("ovr_rts_back", {31'h0, rts}, 32'd1);
    check("ovr_xfers", 32'(xfer_cnt - x0), 32'd1);

    // Back-to-back 0x00 then 0xFF
    x0 = xfer_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
    @(posedge clk); #1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain("drain_b2b", 40);
    check("b2b_xfers", 32'(xfer_cnt - x0), 32'd2);
    check("b2b_errs", 32'((ferr_cnt - f0) + (oerr_cnt - o0)), 32'd0);

    // Asynchronous reset during data bit 3
    hold_bit(1'b0, CPB + 3 * CPB + HALF);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    rxd = 1'b1;
    #17;
    rst_n = 1'b1;
    hold_bit(1'b1, 2 * CPB);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_drain("drain_81", 40);

    repeat (4) @(negedge clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    check("total_ferr", 32'(ferr_cnt), 32'd1);
    check("total_oerr", 32'(oerr_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
